sp_unit: RTL and testbench

Stack pointer unit for the MiniRISC core. It tracks an empty-descending stack: SP always holds the address of the next free slot. It services PUSH, POP, simultaneous push/pop and direct SP load requests from the control unit. For each accepted request it registers the updated SP and the data-memory address of the access. Decrement uses a dedicated ripple-borrow sub-module; increment is the matching +1 path.

---
 rtl/sp_pkg.sv | 34 +++
 rtl/sp_unit_if.sv | 34 +++
 rtl/sp_unit_sub.sv | 24 ++
 rtl/sp_unit.sv | 122 ++++++++++++
 tb/tb_sp_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sp_pkg.sv
// Purpose: shared types and defaults for the stack pointer unit.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package sp_pkg;

    localparam int          SP_WIDTH     = 32;
    localparam logic [31:0] SP_STACK_TOP = 32'h0000_03FF;
    localparam int          SP_DEPTH     = 256;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_LOAD
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_e;

    // Priority decode: load beats swap, swap beats single push/pop.
    function automatic op_e decode_op(input logic push, input logic pop, input logic ld);
        op_e op;
        if (ld)               op = OP_LOAD;
        else if (push && pop) op = OP_SWAP;
        else if (push)        op = OP_PUSH;
        else if (pop)         op = OP_POP;
        else                  op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/sp_unit_if.sv
// Purpose: request/response bundle between the control unit and sp_unit.
// Latency: n/a (wires only).
// Backpressure: none; every sampled request is acknowledged one cycle later.
// Ports: requests push_req/pop_req/ld_req/ld_data/clr_err (master -> slave);
//        responses ack/err/mem_addr/sp/empty/full/ovf_err/unf_err (slave -> master).
interface sp_unit_if
    import sp_pkg::*;
#(
    parameter int WIDTH = SP_WIDTH
);
    logic             push_req;
    logic             pop_req;
    logic             ld_req;
    logic [WIDTH-1:0] ld_data;
    logic             clr_err;
    logic             ack;
    logic             err;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] sp;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output push_req, pop_req, ld_req, ld_data, clr_err,
        input  ack, err, mem_addr, sp, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  push_req, pop_req, ld_req, ld_data, clr_err,
        output ack, err, mem_addr, sp, empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/sp_unit_sub.sv
// Purpose: combinational ripple-borrow decrement by one (modulo 2^WIDTH).
// Latency: 0 cycles, purely combinational.
// Backpressure: n/a.
// Ports: din (operand), dout (din - 1). WIDTH must be at least 2.
module subtractor_one #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    // b[i] is the borrow out of bit i; the final borrow out is not needed.
    logic [WIDTH-2:0] b;

    assign b[0]    = ~din[0];
    assign dout[0] = ~din[0];

    for (genvar i = 1; i < WIDTH - 1; i++) begin : g_borrow
        assign b[i] = b[i-1] & ~din[i];
    end

    for (genvar i = 1; i < WIDTH; i++) begin : g_diff
        assign dout[i] = din[i] ^ b[i-1];
    end
endmodule

// File: rtl/sp_unit.sv
// Purpose: empty-descending stack pointer with push/pop/swap/load ops.
// Latency: 1 cycle request-to-ack; sp/mem_addr/err valid in the ack cycle.
// Backpressure: none; held requests issue one op per cycle.
// Ports: clk, rst_n (async active-low), bus (sp_unit_if.slave).
// Config: SP_BOUNDS_CHECK_EN enables full/empty rejection and sticky error flags.
module sp_unit
    import sp_pkg::*;
#(
    parameter int               WIDTH     = SP_WIDTH,
    parameter logic [WIDTH-1:0] STACK_TOP = WIDTH'(SP_STACK_TOP),
    parameter int               DEPTH     = SP_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    sp_unit_if.slave  bus
);
    localparam logic [WIDTH-1:0] FULL_SP = STACK_TOP - WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           state_q, state_d;
    op_e              op;
    logic             reject;
    logic [WIDTH-1:0] sp_q, sp_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] sp_inc, sp_dec;
    logic             is_empty, is_full;

    assign sp_inc   = sp_q + ONE;
    assign is_empty = (sp_q == STACK_TOP);
    assign is_full  = (sp_q == FULL_SP);

    subtractor_one #(.WIDTH(WIDTH)) u_dec (
        .din  (sp_q),
        .dout (sp_dec)
    );

    always_comb begin
        op      = decode_op(bus.push_req, bus.pop_req, bus.ld_req);
        sp_d    = sp_q;
        addr_d  = addr_q;
        state_d = ST_IDLE;

        // Rejected push/pop still report the would-be address; only sp holds.
        case (op)
            OP_LOAD: begin
                sp_d   = bus.ld_data;
                addr_d = bus.ld_data;
            end
            OP_SWAP: addr_d = sp_inc;
            OP_PUSH: begin
                addr_d = sp_q;
                if (!reject) sp_d = sp_dec;
            end
            OP_POP: begin
                addr_d = sp_inc;
                if (!reject) sp_d = sp_inc;
            end
            default: ;
        endcase

        // ACK only persists when a fresh op lands on the same edge.
        case (state_q)
            ST_IDLE: if (op != OP_NONE) state_d = ST_ACK;
            ST_ACK:  if (op != OP_NONE) state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sp_q    <= STACK_TOP;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.ack      = (state_q == ST_ACK);
    assign bus.sp       = sp_q;
    assign bus.mem_addr = addr_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;

`ifdef SP_BOUNDS_CHECK_EN
    logic err_q, ovf_q, unf_q;
    logic ovf_set, unf_set;

    assign reject  = ((op == OP_PUSH) && is_full) ||
                     (((op == OP_POP) || (op == OP_SWAP)) && is_empty);
    assign ovf_set = reject && (op == OP_PUSH);
    assign unf_set = reject && (op != OP_PUSH);

    // Clear first, then set, so a new error on a clearing edge survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            err_q <= reject;
            ovf_q <= (ovf_q & ~bus.clr_err) | ovf_set;
            unf_q <= (unf_q & ~bus.clr_err) | unf_set;
        end
    end

    assign bus.err     = err_q;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`else
    logic unused_clr_err;

    assign reject         = 1'b0;
    assign unused_clr_err = bus.clr_err;
    assign bus.err        = 1'b0;
    assign bus.ovf_err    = 1'b0;
    assign bus.unf_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sp_unit.sv
// Purpose: self-checking bench for sp_unit (STACK_TOP=0x3FF, DEPTH=4).
// Latency: expects ack and updated state one cycle after each request.
// Backpressure: none; requests are issued back-to-back.
module tb_sp_unit;
    import sp_pkg::*;

    localparam logic [31:0] TOP   = 32'h0000_03FF;
    localparam int          DEP   = 4;
    localparam logic [31:0] FULLV = TOP - 32'(DEP);
`ifdef SP_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_unit_if #(.WIDTH(32)) bus ();

    sp_unit #(
        .WIDTH     (32),
        .STACK_TOP (TOP),
        .DEPTH     (DEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_sp;
    logic        m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        bus.ld_req   = 1'b0;
        bus.ld_data  = '0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic check_state();
        check("sp",      bus.sp,                m_sp);
        check("empty",   32'(bus.empty),        32'(m_sp == TOP));
        check("full",    32'(bus.full),         32'(m_sp == FULLV));
        check("ovf_err", 32'(bus.ovf_err),      32'(m_ovf));
        check("unf_err", 32'(bus.unf_err),      32'(m_unf));
    endtask

    // Drive one request at the falling edge, update the reference model and
    // the scoreboard, then compare the DUT just after the sampling edge.
    task automatic do_op(input logic p, input logic q, input logic l,
                         input logic [31:0] d, input logic c);
        exp_t        e;
        logic        rej;
        logic        is_op;
        logic [31:0] nsp;

        @(negedge clk);
        bus.push_req = p;
        bus.pop_req  = q;
        bus.ld_req   = l;
        bus.ld_data  = d;
        bus.clr_err  = c;

        is_op  = p | q | l;
        rej    = 1'b0;
        nsp    = m_sp;
        e.addr = '0;
        if (l) begin
            nsp    = d;
            e.addr = d;
        end else if (p && q) begin
            e.addr = m_sp + 1;
            rej    = BC && (m_sp == TOP);
        end else if (p) begin
            e.addr = m_sp;
            rej    = BC && (m_sp == FULLV);
            if (!rej) nsp = m_sp - 1;
        end else if (q) begin
            e.addr = m_sp + 1;
            rej    = BC && (m_sp == TOP);
            if (!rej) nsp = m_sp + 1;
        end
        if (BC) begin
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (rej && !q) m_ovf = 1'b1;
            if (rej && q)  m_unf = 1'b1;
        end
        e.err = rej;
        m_sp  = nsp;
        if (is_op) sb.push_back(e);

        @(posedge clk);
        #1;
        clear_inputs();
        check("ack", 32'(bus.ack), 32'(is_op));
        if (bus.ack) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("err",      32'(bus.err), 32'(e.err));
                check("mem_addr", bus.mem_addr, e.addr);
            end
        end else begin
            check("err_idle", 32'(bus.err), 32'd0);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        check_state();
    endtask

    initial begin
        clear_inputs();
        m_sp  = TOP;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack",      32'(bus.ack), 32'd0);
        check("rst_err",      32'(bus.err), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check_state();
        rst_n = 1'b1;

        // Fill the stack, then push once more while full
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Pop on empty, then a normal pop
        do_op(1'b0, 1'b0, 1'b1, TOP, 1'b0);
        do_op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, '0, 1'b1);
        do_op(1'b0, 1'b0, 1'b1, 32'h3FD, 1'b0);
        do_op(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Swap, and swap overridden by load
        do_op(1'b0, 1'b0, 1'b1, 32'h3FD, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, '0, 1'b0);
        do_op(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);

        // Swap on empty
        do_op(1'b0, 1'b0, 1'b1, TOP, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Wrap-around both ways
        do_op(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        do_op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        do_op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_op(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // New overflow on the same edge as clr_err keeps the flag
        do_op(1'b0, 1'b0, 1'b1, FULLV, 1'b0);
        do_op(1'b1, 1'b0, 1'b0, '0, 1'b1);
        do_op(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Random traffic around the valid window
        do_op(1'b0, 1'b0, 1'b1, TOP, 1'b0);
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  1'($urandom_range(15, 0) == 0),
                  32'($urandom_range(32'h402, 32'h3F8)),
                  1'($urandom_range(7, 0) == 0));
        end

        // Reset asserted during an ack cycle
        do_op(1'b0, 1'b0, 1'b1, 32'h3FD, 1'b0);
        @(negedge clk);
        bus.push_req = 1'b1;
        @(posedge clk);
        #1;
        bus.push_req = 1'b0;
        check("pre_rst_ack", 32'(bus.ack), 32'd1);
        check("pre_rst_sp",  bus.sp,       32'h3FC);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(bus.ack), 32'd0);
        check("rst_mid_sp",  bus.sp,       TOP);
        m_sp  = TOP;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, '0, 1'b0);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
